// File: rtl/somador_pkg.sv
// Shared constants and sizing helper for the pipelined signed adder/subtractor.
package somador_pkg;

  localparam logic OP_SOMA = 1'b1;
  localparam logic OP_SUB  = 1'b0;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CHUNK_DEF = 4;

  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/somador_fatia.sv
// One CHUNK-bit slice of the ripple adder: sum, carry out and carry into the slice MSB.
module somador_fatia
  import somador_pkg::*;
#(
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] low;
  logic [1:0]       top;

  // Split at the MSB so the carry into it is visible for overflow detection.
  always_comb begin
    low  = {1'b0, x[CHUNK-2:0]} + {1'b0, y[CHUNK-2:0]} + CHUNK'(cin);
    top  = {1'b0, x[CHUNK-1]} + {1'b0, y[CHUNK-1]} + {1'b0, low[CHUNK-1]};
    sum  = {top[0], low[CHUNK-2:0]};
    cout = top[1];
    cmsb = low[CHUNK-1];
  end

endmodule

// File: rtl/somador_pipeline.sv
// Pipelined signed adder/subtractor, one CHUNK-bit slice per stage, valid/ready streaming.
// Define SOMADOR_SAT_EN to clamp overflowing results instead of wrapping.
module somador_pipeline
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // Requires WIDTH >= 2*CHUNK and CHUNK >= 2.
  localparam int unsigned STAGES  = calc_stages(WIDTH, CHUNK);
  localparam int unsigned NP      = STAGES - 1;
  localparam int unsigned TOP_LSB = (STAGES - 1) * CHUNK;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cin0;

  logic [CHUNK-1:0] x_w    [STAGES];
  logic [CHUNK-1:0] y_w    [STAGES];
  logic [CHUNK-1:0] sum_w  [STAGES];
  logic             ci_w   [STAGES];
  logic             cout_w [STAGES];
  logic             cmsb_w [STAGES];

  // w_q[k] carries finished sum chunks 0..k below the still-pending chunks of A.
  logic             v_q [NP];
  logic             c_q [NP];
  logic [WIDTH-1:0] w_q [NP];
  logic [WIDTH-1:0] w_d [NP];
  logic [WIDTH-1:0] b_q [NP];

  logic             out_valid_q;
  logic             overflow_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] full_w;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  always_comb begin
    adv     = !out_valid_q || out_ready;
    bx      = (op == OP_SOMA) ? b : ~b;
    cin0    = (op == OP_SUB);
    x_w[0]  = a[CHUNK-1:0];
    y_w[0]  = bx[CHUNK-1:0];
    ci_w[0] = cin0;
    for (int k = 1; k < STAGES; k++) begin
      x_w[k]  = w_q[k-1][k*CHUNK +: CHUNK];
      y_w[k]  = b_q[k-1][k*CHUNK +: CHUNK];
      ci_w[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_fatia
    somador_fatia #(
      .CHUNK (CHUNK)
    ) u_fatia (
      .x    (x_w[k]),
      .y    (y_w[k]),
      .cin  (ci_w[k]),
      .sum  (sum_w[k]),
      .cout (cout_w[k]),
      .cmsb (cmsb_w[k])
    );
  end

  always_comb begin
    w_d[0] = {a[WIDTH-1:CHUNK], sum_w[0]};
    for (int k = 1; k < NP; k++) begin
      w_d[k]                    = w_q[k-1];
      w_d[k][k*CHUNK +: CHUNK]  = sum_w[k];
    end
    full_w = {sum_w[STAGES-1], w_q[NP-1][TOP_LSB-1:0]};
    ovf_d  = cmsb_w[STAGES-1] ^ cout_w[STAGES-1];
`ifdef SOMADOR_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    if (ovf_d) begin
      res_d = full_w[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res_d = full_w;
    end
`else
    res_d = full_w;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NP; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        w_q[k] <= '0;
        b_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      c_q[0] <= cout_w[0];
      w_q[0] <= w_d[0];
      b_q[0] <= bx;
      for (int k = 1; k < NP; k++) begin
        v_q[k] <= v_q[k-1];
        c_q[k] <= cout_w[k];
        w_q[k] <= w_d[k];
        b_q[k] <= b_q[k-1];
      end
      out_valid_q <= v_q[NP-1];
      if (v_q[NP-1]) begin
        result_q   <= res_d;
        overflow_q <= ovf_d;
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_somador_pipeline.sv
// Self-checking bench for somador_pipeline: directed table, hand sequences and random stream.
module tb_somador_pipeline;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;

  int nvec = 0;
  int nerr = 0;

  logic [16:0] exp_q [$];

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res_w;
    logic [15:0] res_s;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];

  always #5 clock = ~clock;

  somador_pipeline #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain integer arithmetic on the true signed values.
  function automatic logic [16:0] ref_model(input logic o, input logic [15:0] x,
                                            input logic [15:0] y);
    int          t;
    logic [15:0] r;
    logic        v;
    t = o ? (int'($signed(x)) + int'($signed(y))) : (int'($signed(x)) - int'($signed(y)));
    v = (t > 32767) || (t < -32768);
    r = t[15:0];
`ifdef SOMADOR_SAT_EN
    if (v) r = (t > 0) ? 16'h7fff : 16'h8000;
`endif
    return {v, r};
  endfunction

  // Scoreboard and handshake monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_res;
  logic        prev_ovf;

  always @(negedge clock) begin
    logic [16:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", 32'(result), 32'(prev_res));
        chk("stall_ovf", 32'(overflow), 32'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 32'(result), 32'(e[15:0]));
          chk("sb_ovf", 32'(overflow), 32'(e[16]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(op, a, b));
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_ovf   = overflow;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string nm, input vec_t v);
    int lat;
    in_valid = 1'b1;
    op       = v.op;
    a        = v.a;
    b        = v.b;
    @(negedge clock);
    chk({nm, "_accept"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    lat      = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
`ifdef SOMADOR_SAT_EN
    chk({nm, "_result"}, 32'(result), 32'(v.res_s));
`else
    chk({nm, "_result"}, 32'(result), 32'(v.res_w));
`endif
    chk({nm, "_ovf"}, 32'(overflow), 32'(v.ovf));
    step();
  endtask

  task automatic drain(input string nm);
    int i;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    i         = 0;
    while (exp_q.size() != 0 && i < 100) begin
      step();
      i++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner [4];
    corner = '{16'h7fff, 16'h8000, 16'h0000, 16'hffff};
    if ($urandom_range(0, 5) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic stream(input int ncyc);
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op       = 1'($urandom);
        a        = pick_operand();
        b        = pick_operand();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = in_valid && in_ready;
      step();
    end
    drain("stream");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] bb_exp [6];

    tbl[0]  = '{1'b1, 16'd35,        16'd72,        16'd107,       16'd107,       1'b0};
    tbl[1]  = '{1'b1, 16'sd32512,    16'sd256,      16'h8000,      16'h7fff,      1'b1};
    tbl[2]  = '{1'b0, -16'sd28576,   16'sd25604,    16'sd11356,    16'h8000,      1'b1};
    tbl[3]  = '{1'b0, -16'sd256,     16'sd256,      -16'sd512,     -16'sd512,     1'b0};
    tbl[4]  = '{1'b0, 16'sd502,      16'sd124,      16'sd378,      16'sd378,      1'b0};
    tbl[5]  = '{1'b1, 16'h8000,      -16'sd1,       16'h7fff,      16'h8000,      1'b1};
    tbl[6]  = '{1'b0, 16'h0000,      16'h8000,      16'h8000,      16'h7fff,      1'b1};
    tbl[7]  = '{1'b1, -16'sd1,       16'sd1,        16'h0000,      16'h0000,      1'b0};
    tbl[8]  = '{1'b0, 16'h8000,      16'sd1,        16'h7fff,      16'h8000,      1'b1};
    tbl[9]  = '{1'b1, 16'sd32767,    16'h8000,      16'hffff,      16'hffff,      1'b0};
    tbl[10] = '{1'b0, 16'sd32767,    -16'sd1,       16'h8000,      16'h7fff,      1'b1};
    tbl[11] = '{1'b1, -16'sd100,     -16'sd200,     -16'sd300,     -16'sd300,     1'b0};

    in_valid  = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_one($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back: six ops on consecutive edges must exit on consecutive edges, 4-cycle latency.
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        in_valid  = 1'b1;
        op        = 1'($urandom);
        a         = pick_operand();
        b         = pick_operand();
        bb_exp[c] = ref_model(op, a, b);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 3 && c <= 8) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(result), 32'(bb_exp[c-3][15:0]));
        chk("b2b_ovf", 32'(overflow), 32'(bb_exp[c-3][16]));
      end else begin
        chk("b2b_idle", 32'(out_valid), 32'd0);
      end
    end
    drain("b2b");

    // Backpressure with a full pipeline and a pending input.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      op       = 1'($urandom);
      a        = pick_operand();
      b        = pick_operand();
      step();
    end
    op        = 1'b1;
    a         = 16'sd1000;
    b         = -16'sd3;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    drain("bp");

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      op       = 1'($urandom);
      a        = pick_operand();
      b        = pick_operand();
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    run_one("rst_next", tbl[4]);

    stream(1500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/somador_pipeline.md
# somador_pipeline

Parametrised, pipelined signed adder/subtractor that computes `a + b` or `a - b` on WIDTH-bit two's-complement operands, one chunk of CHUNK bits per pipeline stage, with signed-overflow detection. It accepts one operation per cycle through a valid/ready handshake and stalls the whole pipeline under output backpressure. It is the clocked, streaming successor of the combinational `somador` and sits between operand producers and any consumer of arithmetic results in the datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (default 4).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- op  in  1  1 = add (a+b), 0 = subtract (a-b).
- out_valid  out  1  result and overflow valid.
- out_ready  in  1  consumer accepts result this cycle.
- result  out  WIDTH  signed result.
- overflow  out  1  signed overflow of the operation.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- Global advance enable `adv = !out_valid || out_ready`; `in_ready = adv` (combinational). When `adv` = 0, every stage register, including result/overflow, holds.
- Subtract: B is bitwise inverted and carry-in to chunk 0 = 1; add: carry-in = 0.
- Stage k (0..STAGES-1) adds chunk k of A and B' with the carry registered from stage k-1; upper chunks of A/B' and lower sum chunks travel delayed in skew registers so each word exits aligned.
- Overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
- A bubble (no transfer in) propagates as valid = 0; data registers of invalid stages are don't-care except the output registers.
- Result wraps modulo 2^WIDTH (unless saturation compiled in).

## Timing
- Latency: operands accepted at edge N appear with out_valid = 1 after edge N+STAGES-1 (i.e. STAGES register stages; output is registered).
- Throughput: one operation per cycle while out_ready = 1.
- Stall: while `out_valid && !out_ready`, in_ready = 0, result/overflow/out_valid stable; no operation is lost or duplicated.
- Simultaneous out transfer and in transfer in the same cycle: allowed, pipeline advances.
- Reset (async, any time, including mid-stream): all stage valid bits 0, out_valid = 0, result = 0, overflow = 0; in-flight operations are discarded; in_ready = 1 from the first cycle after reset deasserts.

## Configuration
- `SOMADOR_SAT_EN` defined: when overflow = 1, result clamps to max positive (0111…1) if the true result is positive, min negative (1000…0) if negative; overflow still reports 1.
- Undefined: result is the wrapped WIDTH-bit sum; overflow flag identical.

## Structure
- Package `somador_pkg`: constants OP_SOMA = 1'b1, OP_SUB = 1'b0; default WIDTH/CHUNK; function computing STAGES.
- Sub-module `somador_fatia`: combinational CHUNK-bit adder with cin, producing sum, cout and carry-into-MSB; instantiated once per stage via generate.

## Test plan
- op=1, a=35, b=72 -> after 4 cycles result=107, overflow=0.
- op=1, a=32512, b=256 -> overflow=1, result=-32768 (wrap) or 32767 with SOMADOR_SAT_EN.
- op=0, a=-28576, b=25604 -> overflow=1, result=11356 (wrap) or -32768 with SOMADOR_SAT_EN; op=0, a=-256, b=256 -> -512, overflow=0.
- Back-to-back: 6 operations on consecutive cycles with out_ready=1 -> 6 results on consecutive cycles in order, latency 4 each.
- Backpressure: out_ready=0 for 3 cycles with full pipeline -> in_ready=0, result held stable, all results delivered in order once out_ready=1, none dropped or repeated.
- Reset mid-stream with 3 ops in flight -> out_valid=0, result=0, overflow=0 immediately; no stale result appears afterwards; next op (502-124) yields 378 after 4 cycles.
